// File: rtl/tone_sequencer.sv
// tone_sequencer: pattern sequencer driving the sound card's voice-enable inputs.
//
// A writable pattern memory holds entries of {mask, dur}. On start, steps 0..length are
// played in order; each mask is held for dur tempo ticks (dur=0 plays as 1 tick), where
// one tick is PRESCALE clk cycles. After the last step playback either wraps to step 0
// or finishes with a one-cycle done pulse.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset (pattern memory is preserved)
//   wr_en      - pattern write strobe
//   wr_addr    - pattern entry to write
//   wr_data    - {mask[VOICES-1:0], dur[DUR_W-1:0]}
//   start      - begin (or restart) playback from step 0
//   stop       - abort playback; has priority over start
//   loop_en    - 1: wrap to step 0 after the last step, 0: finish
//   length     - index of the last step played
//   voice_mask - registered voice enables
//   step_idx   - current step index
//   busy       - high while playing
//   done       - one-cycle pulse on natural completion
module tone_sequencer #(
    parameter int unsigned VOICES   = 4,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned PRESCALE = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [VOICES+DUR_W-1:0] wr_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [ADDR_W-1:0]       length,
    output logic [VOICES-1:0]       voice_mask,
    output logic [ADDR_W-1:0]       step_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e                    state_q, state_d;
    logic [VOICES-1:0]         mask_q, mask_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic [PRE_W-1:0]          presc_q, presc_d;
    logic [DUR_W-1:0]          dur_q, dur_d;
    logic                      done_q, done_d;

    logic [VOICES+DUR_W-1:0]   mem_q [DEPTH];

    logic                      load_en;
    logic [ADDR_W-1:0]         load_idx;
    logic [VOICES+DUR_W-1:0]   load_entry;
    logic [DUR_W-1:0]          load_dur;

    // Pattern memory has no reset so a loaded pattern survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        presc_d    = presc_q;
        dur_d      = dur_q;
        done_d     = 1'b0;
        load_en    = 1'b0;
        load_idx   = '0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    load_en = 1'b1;
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                    mask_d  = '0;
                    idx_d   = '0;
                end else if (start) begin
                    load_en = 1'b1;
                end else if (presc_q == '0) begin
                    presc_d = PRE_MAX;
                    if (dur_q > DUR_W'(1)) begin
                        dur_d = dur_q - DUR_W'(1);
                    end else if (idx_q != length) begin
                        // Equality only: a length below idx wraps through the top of memory.
                        load_en  = 1'b1;
                        load_idx = idx_q + ADDR_W'(1);
                    end else if (loop_en) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = StIdle;
                        mask_d  = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q - PRE_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Step load reads the array as it stands before this edge's write.
        load_entry = mem_q[load_idx];
        load_dur   = load_entry[DUR_W-1:0];
        if (load_en) begin
            idx_d   = load_idx;
            mask_d  = load_entry[VOICES+DUR_W-1:DUR_W];
            dur_d   = (load_dur == '0) ? DUR_W'(1) : load_dur;
            presc_d = PRE_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mask_q  <= '0;
            idx_q   <= '0;
            presc_q <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    assign voice_mask = mask_q;
    assign step_idx   = idx_q;
    assign busy       = (state_q == StPlay);
    assign done       = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus random traffic, every cycle compared
// against a step/remaining-cycles reference model.
module tb_tone_sequencer;

    localparam int unsigned V = 4;
    localparam int unsigned A = 4;
    localparam int unsigned D = 8;
    localparam int unsigned P = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [A-1:0]     wr_addr = '0;
    logic [V+D-1:0]   wr_data = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [A-1:0]     length = '0;
    logic [V-1:0]     voice_mask;
    logic [A-1:0]     step_idx;
    logic             busy;
    logic             done;

    tone_sequencer #(
        .VOICES   (V),
        .ADDR_W   (A),
        .DUR_W    (D),
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .length     (length),
        .voice_mask (voice_mask),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int done_seen = 0;

    // Reference model: which step plays and how many clk cycles it has left.
    logic [V+D-1:0] m_mem [16];
    logic           m_play = 1'b0;
    int             m_idx  = 0;
    int             m_left = 0;
    logic [V-1:0]   m_mask = '0;
    logic           m_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_load(input int k);
        int d;
        m_idx  = k;
        m_mask = m_mem[k][V+D-1:D];
        d      = int'(m_mem[k][D-1:0]);
        if (d == 0) d = 1;
        m_left = d * P;
    endtask

    task automatic m_finish(input logic with_done);
        m_play = 1'b0;
        m_mask = '0;
        m_idx  = 0;
        m_done = with_done;
    endtask

    task automatic model_step(input logic s, input logic p, input logic w,
                              input logic [A-1:0] wa, input logic [V+D-1:0] wd,
                              input logic le, input logic [A-1:0] len);
        m_done = 1'b0;
        if (!m_play) begin
            if (s && !p) begin
                m_load(0);
                m_play = 1'b1;
            end
        end else if (p) begin
            m_finish(1'b0);
        end else if (s) begin
            m_load(0);
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_idx != int'(len)) m_load((m_idx + 1) % 16);
                else if (le) m_load(0);
                else m_finish(1'b1);
            end
        end
        if (w) m_mem[wa] = wd;
    endtask

    task automatic compare_all();
        check_eq("voice_mask", 32'(voice_mask), 32'(m_mask));
        check_eq("step_idx", 32'(step_idx), 32'(m_idx));
        check_eq("busy", 32'(busy), 32'(m_play));
        check_eq("done", 32'(done), 32'(m_done));
        if (done) done_seen++;
    endtask

    task automatic cycle();
        logic s, p, w, le, r;
        logic [A-1:0] wa, len;
        logic [V+D-1:0] wd;
        s = start; p = stop; w = wr_en; wa = wr_addr; wd = wr_data;
        le = loop_en; len = length; r = reset;
        @(posedge clk);
        if (r) begin
            m_finish(1'b0);
            if (w) m_mem[wa] = wd;
        end else begin
            model_step(s, p, w, wa, wd, le, len);
        end
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_entry(input int a, input logic [V-1:0] m, input logic [D-1:0] d);
        wr_en = 1'b1; wr_addr = A'(a); wr_data = {m, d};
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic load_base_pattern();
        write_entry(0, 4'b0001, 8'd2);
        write_entry(1, 4'b0010, 8'd1);
        write_entry(2, 4'b0100, 8'd3);
        length = 4'd2;
    endtask

    initial begin
        // Reset state, then fill memory so every entry is known.
        run(2);
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            write_entry(a, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));
        end

        // 1: single pass, finishes after 24 cycles with one done pulse.
        load_base_pattern();
        loop_en = 1'b0;
        done_seen = 0;
        pulse_start();
        run(30);
        check_eq("s1_done_count", 32'(done_seen), 32'd1);

        // 2: looping, then drop loop_en so the second pass ends.
        loop_en = 1'b1;
        done_seen = 0;
        pulse_start();
        run(30);
        loop_en = 1'b0;
        run(30);
        check_eq("s2_done_count", 32'(done_seen), 32'd1);

        // 3: zero duration plays as one tick.
        write_entry(0, 4'b1010, 8'd0);
        length = 4'd0;
        pulse_start();
        run(8);

        // 4: stop mid-play, then start+stop together while idle.
        load_base_pattern();
        done_seen = 0;
        pulse_start();
        run(5);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(5);
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        run(3);
        check_eq("s4_done_count", 32'(done_seen), 32'd0);

        // 5: asynchronous reset mid-cycle, then idle until a new start.
        pulse_start();
        run(9);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_mask", 32'(voice_mask), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_idx", 32'(step_idx), 32'd0);
        m_finish(1'b0);
        cycle();
        reset = 1'b0;
        run(10);

        // 6: rewrite the active step during looped play.
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 40 && m_idx != 1; i++) cycle();
        check_eq("s6_at_step1", 32'(step_idx), 32'd1);
        write_entry(1, 4'b1000, 8'd1);
        run(30);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // Random traffic, including lengths below the current step.
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 99) < 15);
            wr_addr = A'($urandom_range(0, 15));
            wr_data = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 3))};
            start   = ($urandom_range(0, 99) < 3);
            stop    = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 99) < 2) loop_en = ~loop_en;
            if ($urandom_range(0, 99) < 2) length = A'($urandom_range(0, 15));
            cycle();
        end
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Pattern sequencer that drives the 4-bit voice-enable input of the sound card. It holds a small writable pattern memory; each entry is a voice mask plus a duration in tempo ticks. On start it steps through entries 0..length and outputs each mask for its duration, then stops or loops. A host or button logic loads the pattern; voice_mask connects directly to the sound card's switch inputs.

Parameters:
VOICES, 4, voice-mask width; equals sound card switch count
ADDR_W, 4, pattern address width; memory depth is 2**ADDR_W
DUR_W, 8, step duration width, in ticks
PRESCALE, 1000, clk cycles per tempo tick; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  pattern write strobe
wr_addr  input  ADDR_W  pattern entry to write
wr_data  input  VOICES+DUR_W  {mask[VOICES-1:0], dur[DUR_W-1:0]}
start  input  1  begin playback from step 0 (level sampled per cycle)
stop  input  1  abort playback
loop_en  input  1  1: wrap to step 0 after last step; 0: finish
length  input  ADDR_W  index of last step played
voice_mask  output  VOICES  registered voice enables to sound card
step_idx  output  ADDR_W  current step index
busy  output  1  high in PLAY state
done  output  1  one-cycle pulse on natural completion

Behaviour:
- Reset (async assert): state=IDLE, voice_mask=0, step_idx=0, busy=0, done=0, prescaler=0, dur_cnt=0. Pattern memory is not cleared.
- Memory: written on any cycle with wr_en, including during PLAY. A write to the current step affects that step only on its next load.
- Memory read is combinational from the array.
- States: IDLE and PLAY; busy = (state==PLAY).
- Step load (used by start and by advance), for step k:
  - step_idx<=k, voice_mask<=mem[k].mask
  - dur_cnt<=max(mem[k].dur,1); dur=0 is treated as 1 tick
  - prescaler<=PRESCALE-1
- IDLE: start=1 and stop=0 -> load step 0, go to PLAY. The mask is visible the cycle after the start edge.
- PLAY, each cycle:
  - If prescaler==0: tick; prescaler<=PRESCALE-1. Otherwise prescaler decrements.
  - On tick with dur_cnt>1: dur_cnt decrements.
  - On tick with dur_cnt==1, step_idx<length: load step_idx+1.
  - On tick with dur_cnt==1, step_idx==length, loop_en=1: load step 0.
  - On tick with dur_cnt==1, step_idx==length, loop_en=0: voice_mask<=0, step_idx<=0, done<=1 for one cycle, go to IDLE.
- Timing: each step lasts exactly dur*PRESCALE clk cycles. No gap cycles between steps or across the loop wrap.
- loop_en and length are sampled at the tick that ends the last step. Changing them mid-play is legal.
- If length is lowered below the current step_idx, playback continues incrementing and wraps naturally at 2**ADDR_W-1 -> 0. Comparison is equality only.
- stop=1 in PLAY: next edge goes to IDLE, voice_mask=0, step_idx=0, no done pulse.
- stop=1 and start=1 in the same cycle: stop wins in both states.
- start=1 in PLAY (stop=0): restart by loading step 0. done is not asserted.
- done=0 on every cycle except the single completion cycle.
- Reset asserted mid-play: outputs go to reset values immediately. Playback does not resume after deassert until a new start.

Test Plan:
1. PRESCALE=4. Write {0001,2},{0010,1},{0100,3} to addr 0..2; length=2, loop_en=0; pulse start at edge E0 -> voice_mask=0001 over E0..E8, 0010 over E8..E12, 0100 over E12..E24. At E24: mask=0, busy=0, done=1 for exactly one cycle.
2. Same pattern with loop_en=1 -> at E24 mask returns to 0001, step_idx=0, no done; second loop ends at E48 identically.
3. Entry 0 = {1010,0}, length=0, loop_en=0 -> mask 1010 for exactly 4 cycles, then done pulse.
4. stop asserted at E6 during scenario 1 -> mask=0 and busy=0 after E7, no done pulse. start and stop together in IDLE -> stays IDLE.
5. Reset asserted asynchronously mid-cycle at ~E10 -> voice_mask=0, busy=0 before the next clk edge. After deassert, idle until start.
6. During looped play, write addr 1 = {1000,1} while step 1 is active -> the current step is unchanged; the next pass outputs 1000 at step 1.
